// File: rtl/octal_seg_pkg.sv
// Shared definitions for the octal seven-segment display reader:
// segment pattern constants (gfedcba, active-high), error codes, the
// reader FSM state type and a digit-index to one-hot select helper.
package octal_seg_pkg;

    localparam logic [6:0] SEG_OCT_0 = 7'h3F;
    localparam logic [6:0] SEG_OCT_1 = 7'h06;
    localparam logic [6:0] SEG_OCT_2 = 7'h5B;
    localparam logic [6:0] SEG_OCT_3 = 7'h4F;
    localparam logic [6:0] SEG_OCT_4 = 7'h66;
    localparam logic [6:0] SEG_OCT_5 = 7'h6D;
    localparam logic [6:0] SEG_OCT_6 = 7'h7D;
    localparam logic [6:0] SEG_OCT_7 = 7'h07;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_PATTERN  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN0 = 3'd1,
        ST_SCAN1 = 3'd2,
        ST_SCAN2 = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAIL  = 3'd5
    } reader_state_t;

    // Map a digit index (0..2) to its one-hot digit select; index 3 selects nothing.
    function automatic logic [2:0] onehot_sel(input logic [1:0] idx);
        logic [2:0] sel;
        case (idx)
            2'd0:    sel = 3'b001;
            2'd1:    sel = 3'b010;
            2'd2:    sel = 3'b100;
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_to_oct.sv
// Combinational decoder from a seven-segment pattern (gfedcba) to an
// octal digit. Any pattern outside the eight legal glyphs is flagged invalid.
module seg7_to_oct
    import octal_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [2:0] digit,
    output logic       valid
);

    // Look the pattern up in the glyph table; unknown patterns report digit 0 and valid=0.
    always_comb begin
        digit = 3'd0;
        valid = 1'b1;
        case (seg)
            SEG_OCT_0: digit = 3'd0;
            SEG_OCT_1: digit = 3'd1;
            SEG_OCT_2: digit = 3'd2;
            SEG_OCT_3: digit = 3'd3;
            SEG_OCT_4: digit = 3'd4;
            SEG_OCT_5: digit = 3'd5;
            SEG_OCT_6: digit = 3'd6;
            SEG_OCT_7: digit = 3'd7;
            default: begin
                digit = 3'd0;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/octal_display_reader.sv
// Reads back a three-digit multiplexed octal seven-segment display.
// Each digit is selected for SETTLE_CYCLES cycles, then sampled, decoded
// and checked; the three digits are reassembled into an 8-bit value.
// Optional build macro OCTAL_READER_CONFIRM_EN: every request scans two
// full frames and only reports a value when both frames agree.
module octal_display_reader
    import octal_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] seg_in,
    output logic [2:0] dig_sel,
    output logic       busy,
    output logic [7:0] bin_out,
    output logic       bin_valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic [1:0] err_digit
);

    // A single-cycle dwell still needs a 1-bit counter.
    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    reader_state_t     state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [2:0]        dig_sel_r;
    logic              busy_r;
    logic [7:0]        bin_out_r;
    logic              bin_valid_r;
    logic              err_r;
    logic [1:0]        err_code_r;
    logic [1:0]        err_digit_r;
    logic [2:0]        d0_r;
    logic [2:0]        d1_r;

    logic [2:0]        dec_digit_s;
    logic              dec_valid_s;
    logic [1:0]        scan_idx_s;
    logic              scanning_s;
    logic              sample_s;
    logic              overflow_s;

`ifdef OCTAL_READER_CONFIRM_EN
    logic              frame_r;
    logic [2:0]        f_d0_r;
    logic [2:0]        f_d1_r;
    logic [2:0]        f_d2_r;
    logic              mismatch_s;
    logic [1:0]        mismatch_idx_s;
`endif

    // One decoder serves all three scan states; only the selected digit drives seg_in.
    seg7_to_oct u_dec (
        .seg   (seg_in),
        .digit (dec_digit_s),
        .valid (dec_valid_s)
    );

    // Derive the digit index being scanned and whether this edge is its sample point.
    always_comb begin
        scan_idx_s = 2'd0;
        scanning_s = 1'b0;
        case (state_r)
            ST_SCAN0: begin scan_idx_s = 2'd0; scanning_s = 1'b1; end
            ST_SCAN1: begin scan_idx_s = 2'd1; scanning_s = 1'b1; end
            ST_SCAN2: begin scan_idx_s = 2'd2; scanning_s = 1'b1; end
            default:  begin scan_idx_s = 2'd0; scanning_s = 1'b0; end
        endcase
        sample_s = scanning_s && (cnt_r == CNT_ZERO);
        // The MS digit may only carry two bits: 377 octal is the largest byte.
        overflow_s = (state_r == ST_SCAN2) && dec_digit_s[2];
    end

`ifdef OCTAL_READER_CONFIRM_EN
    // Compare the first frame against the second; report the lowest digit that differs.
    always_comb begin
        mismatch_s     = 1'b1;
        mismatch_idx_s = 2'd0;
        if (f_d0_r != d0_r) begin
            mismatch_idx_s = 2'd0;
        end else if (f_d1_r != d1_r) begin
            mismatch_idx_s = 2'd1;
        end else if (f_d2_r != dec_digit_s) begin
            mismatch_idx_s = 2'd2;
        end else begin
            mismatch_s = 1'b0;
        end
    end
`endif

    // Reader FSM: scan digits, validate, assemble the result and drive all outputs from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= CNT_ZERO;
            dig_sel_r   <= 3'b000;
            busy_r      <= 1'b0;
            bin_out_r   <= 8'h00;
            bin_valid_r <= 1'b0;
            err_r       <= 1'b0;
            err_code_r  <= ERR_NONE;
            err_digit_r <= 2'd0;
            d0_r        <= 3'd0;
            d1_r        <= 3'd0;
`ifdef OCTAL_READER_CONFIRM_EN
            frame_r     <= 1'b0;
            f_d0_r      <= 3'd0;
            f_d1_r      <= 3'd0;
            f_d2_r      <= 3'd0;
`endif
        end else begin
            bin_valid_r <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_SCAN0;
                        dig_sel_r <= 3'b001;
                        busy_r    <= 1'b1;
                        cnt_r     <= CNT_LOAD;
`ifdef OCTAL_READER_CONFIRM_EN
                        frame_r   <= 1'b0;
`endif
                    end
                end
                ST_SCAN0, ST_SCAN1, ST_SCAN2: begin
                    if (!sample_s) begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end else if (!dec_valid_s) begin
                        state_r     <= ST_FAIL;
                        dig_sel_r   <= 3'b000;
                        err_r       <= 1'b1;
                        err_code_r  <= ERR_PATTERN;
                        err_digit_r <= scan_idx_s;
                    end else if (overflow_s) begin
                        state_r     <= ST_FAIL;
                        dig_sel_r   <= 3'b000;
                        err_r       <= 1'b1;
                        err_code_r  <= ERR_OVERFLOW;
                        err_digit_r <= 2'd2;
                    end else if (state_r != ST_SCAN2) begin
                        if (state_r == ST_SCAN0) begin
                            d0_r    <= dec_digit_s;
                            state_r <= ST_SCAN1;
                        end else begin
                            d1_r    <= dec_digit_s;
                            state_r <= ST_SCAN2;
                        end
                        dig_sel_r <= onehot_sel(scan_idx_s + 2'd1);
                        cnt_r     <= CNT_LOAD;
`ifdef OCTAL_READER_CONFIRM_EN
                    end else if (!frame_r) begin
                        // First frame complete: remember it and rescan immediately.
                        f_d0_r    <= d0_r;
                        f_d1_r    <= d1_r;
                        f_d2_r    <= dec_digit_s;
                        frame_r   <= 1'b1;
                        state_r   <= ST_SCAN0;
                        dig_sel_r <= 3'b001;
                        cnt_r     <= CNT_LOAD;
                    end else if (mismatch_s) begin
                        state_r     <= ST_FAIL;
                        dig_sel_r   <= 3'b000;
                        err_r       <= 1'b1;
                        err_code_r  <= ERR_MISMATCH;
                        err_digit_r <= mismatch_idx_s;
`endif
                    end else begin
                        state_r     <= ST_DONE;
                        dig_sel_r   <= 3'b000;
                        bin_out_r   <= {dec_digit_s[1:0], d1_r, d0_r};
                        bin_valid_r <= 1'b1;
                    end
                end
                ST_DONE, ST_FAIL: begin
                    // Result cycle ends here; a start seen now is deliberately dropped.
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    dig_sel_r <= 3'b000;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    dig_sel_r <= 3'b000;
                    cnt_r     <= CNT_ZERO;
                end
            endcase
        end
    end

    assign dig_sel   = dig_sel_r;
    assign busy      = busy_r;
    assign bin_out   = bin_out_r;
    assign bin_valid = bin_valid_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign err_digit = err_digit_r;

endmodule

// File: tb/tb_octal_display_reader.sv
// Directed self-checking bench for octal_display_reader with SETTLE_CYCLES=4.
// A behavioural display model answers dig_sel with the pattern of the
// selected digit. Expected latencies follow OCTAL_READER_CONFIRM_EN.
module tb_octal_display_reader;

    localparam int S = 4;
`ifdef OCTAL_READER_CONFIRM_EN
    localparam int FRAMES = 2;
`else
    localparam int FRAMES = 1;
`endif
    localparam int LAT   = 3 * S * FRAMES;
    localparam int NEDGE = 2 * LAT + 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] seg_in;
    logic [2:0] dig_sel;
    logic       busy;
    logic [7:0] bin_out;
    logic       bin_valid;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] err_digit;

    int checks;
    int failures;

    logic [6:0] pat [0:2];
    logic [2:0] sel_hist  [0:NEDGE-1];
    logic       busy_hist [0:NEDGE-1];
    logic [7:0] bout_seen;
    logic [1:0] ecode_seen;
    logic [1:0] edigit_seen;

    octal_display_reader #(.SETTLE_CYCLES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seg_in    (seg_in),
        .dig_sel   (dig_sel),
        .busy      (busy),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .err       (err),
        .err_code  (err_code),
        .err_digit (err_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Display model: show the pattern of whichever digit is selected.
    always @* begin
        case (dig_sel)
            3'b001:  seg_in = pat[0];
            3'b010:  seg_in = pat[1];
            3'b100:  seg_in = pat[2];
            default: seg_in = 7'h00;
        endcase
    end

    // Start one conversion and observe NEDGE edges, optionally swapping digit 0
    // after edge chg_edge and re-pulsing start after edges ra and rb.
    task automatic run_conv(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                            input int chg_edge, input logic [6:0] chg_p0,
                            input int ra, input int rb,
                            output int valid_edge, output int err_edge,
                            output int nvalid, output int nerr, output int nboth);
        pat[0] = p0; pat[1] = p1; pat[2] = p2;
        valid_edge = -1; err_edge = -1; nvalid = 0; nerr = 0; nboth = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sel_hist[0]  = dig_sel;
        busy_hist[0] = busy;
        for (int e = 1; e < NEDGE; e++) begin
            @(posedge clk);
            #1;
            sel_hist[e]  = dig_sel;
            busy_hist[e] = busy;
            if (bin_valid) begin
                nvalid++;
                if (valid_edge < 0) begin valid_edge = e; bout_seen = bin_out; end
            end
            if (err) begin
                nerr++;
                if (err_edge < 0) begin err_edge = e; ecode_seen = err_code; edigit_seen = err_digit; end
            end
            if (bin_valid && err) nboth++;
            if (e == chg_edge) pat[0] = chg_p0;
            start = (e == ra) || (e == rb);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dig_sel !== 3'b000 || busy !== 1'b0 || bin_out !== 8'h00 || bin_valid !== 1'b0 ||
            err !== 1'b0 || err_code !== 2'b00 || err_digit !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got sel=%b busy=%b out=%h v=%b err=%b code=%b dig=%0d, want all zero",
                     dig_sel, busy, bin_out, bin_valid, err, err_code, err_digit);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int ve, ee, nv, ne, nb, bad;
        logic [2:0] exp_sel;
        run_conv(7'h6D, 7'h5B, 7'h4F, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ve !== LAT || nv !== 1 || ne !== 0) begin
            failures++;
            $display("FAIL basic_latency: valid_edge=%0d nvalid=%0d nerr=%0d, want %0d/1/0", ve, nv, ne, LAT);
        end
        checks++;
        if (bout_seen !== 8'hD5) begin
            failures++;
            $display("FAIL basic_value: got %h want d5", bout_seen);
        end
        bad = -1;
        for (int e = 0; e <= LAT; e++) begin
            exp_sel = (e < LAT) ? (3'b001 << ((e / S) % 3)) : 3'b000;
            if (sel_hist[e] !== exp_sel && bad < 0) bad = e;
        end
        checks++;
        if (bad >= 0) begin
            failures++;
            $display("FAIL basic_dig_sel: edge %0d got %b", bad, sel_hist[bad]);
        end
        checks++;
        if (busy_hist[0] !== 1'b1 || busy_hist[LAT] !== 1'b1 || busy_hist[LAT+1] !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: got %b,%b,%b want 1,1,0", busy_hist[0], busy_hist[LAT], busy_hist[LAT+1]);
        end
    endtask

    task automatic test_pattern_error();
        int ve, ee, nv, ne, nb;
        run_conv(7'h6D, 7'h7F, 7'h4F, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ee !== 2 * S || ne !== 1 || nv !== 0) begin
            failures++;
            $display("FAIL pattern_err_timing: err_edge=%0d nerr=%0d nvalid=%0d, want %0d/1/0", ee, ne, nv, 2 * S);
        end
        checks++;
        if (ecode_seen !== 2'b01 || edigit_seen !== 2'd1) begin
            failures++;
            $display("FAIL pattern_err_code: code=%b digit=%0d want 01/1", ecode_seen, edigit_seen);
        end
        checks++;
        if (bin_out !== 8'hD5) begin
            failures++;
            $display("FAIL pattern_err_hold: bin_out=%h want d5", bin_out);
        end
    endtask

    task automatic test_overflow();
        int ve, ee, nv, ne, nb;
        run_conv(7'h3F, 7'h06, 7'h66, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ee !== 3 * S || ne !== 1 || nv !== 0 || ecode_seen !== 2'b10 || edigit_seen !== 2'd2) begin
            failures++;
            $display("FAIL overflow: err_edge=%0d nerr=%0d nvalid=%0d code=%b digit=%0d, want %0d/1/0/10/2",
                     ee, ne, nv, ecode_seen, edigit_seen, 3 * S);
        end
    endtask

    task automatic test_extremes();
        int ve, ee, nv, ne, nb;
        run_conv(7'h3F, 7'h3F, 7'h3F, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ve !== LAT || nv !== 1 || bout_seen !== 8'h00) begin
            failures++;
            $display("FAIL min_value: edge=%0d n=%0d out=%h, want %0d/1/00", ve, nv, bout_seen, LAT);
        end
        run_conv(7'h07, 7'h07, 7'h4F, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ve !== LAT || nv !== 1 || ne !== 0 || bout_seen !== 8'hFF) begin
            failures++;
            $display("FAIL max_value: edge=%0d n=%0d out=%h, want %0d/1/ff", ve, nv, bout_seen, LAT);
        end
    endtask

    task automatic test_mid_reset();
        int ve, ee, nv, ne, nb;
        pat[0] = 7'h6D; pat[1] = 7'h5B; pat[2] = 7'h4F;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dig_sel !== 3'b000 || busy !== 1'b0 || bin_out !== 8'h00 || bin_valid !== 1'b0 ||
            err !== 1'b0 || err_code !== 2'b00 || err_digit !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_state: sel=%b busy=%b out=%h v=%b err=%b code=%b dig=%0d, want all zero",
                     dig_sel, busy, bin_out, bin_valid, err, err_code, err_digit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_conv(7'h6D, 7'h5B, 7'h4F, -1, 7'h00, -1, -1, ve, ee, nv, ne, nb);
        checks++;
        if (ve !== LAT || nv !== 1 || ne !== 0 || bout_seen !== 8'hD5) begin
            failures++;
            $display("FAIL after_reset_conv: edge=%0d n=%0d err=%0d out=%h, want %0d/1/0/d5", ve, nv, ne, bout_seen, LAT);
        end
    endtask

    task automatic test_back_to_back();
        int ve, ee, nv, ne, nb;
        // digits 1,4,0 -> 0x21; restarts mid-scan and during the result cycle
        run_conv(7'h06, 7'h66, 7'h3F, -1, 7'h00, S + 1, LAT, ve, ee, nv, ne, nb);
        checks++;
        if (ve !== LAT || nv !== 1 || ne !== 0 || bout_seen !== 8'h21) begin
            failures++;
            $display("FAIL start_while_busy: edge=%0d n=%0d err=%0d out=%h, want %0d/1/0/21", ve, nv, ne, bout_seen, LAT);
        end
        checks++;
        if (busy_hist[NEDGE-1] !== 1'b0 || nb !== 0) begin
            failures++;
            $display("FAIL busy_after_drop: busy=%b both=%0d, want 0/0", busy_hist[NEDGE-1], nb);
        end
    endtask

    task automatic test_confirm();
        int ve, ee, nv, ne, nb;
        // digit 0 changes from 5 to 1 after the first frame completes
        run_conv(7'h6D, 7'h5B, 7'h4F, 3 * S + 1, 7'h06, -1, -1, ve, ee, nv, ne, nb);
`ifdef OCTAL_READER_CONFIRM_EN
        checks++;
        if (ee !== 6 * S || ne !== 1 || nv !== 0 || ecode_seen !== 2'b11 || edigit_seen !== 2'd0) begin
            failures++;
            $display("FAIL confirm_mismatch: edge=%0d nerr=%0d nvalid=%0d code=%b digit=%0d, want %0d/1/0/11/0",
                     ee, ne, nv, ecode_seen, edigit_seen, 6 * S);
        end
`else
        checks++;
        if (ve !== LAT || nv !== 1 || ne !== 0 || bout_seen !== 8'hD5) begin
            failures++;
            $display("FAIL single_frame_late_change: edge=%0d n=%0d err=%0d out=%h, want %0d/1/0/d5",
                     ve, nv, ne, bout_seen, LAT);
        end
`endif
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        start     = 1'b0;
        rst_n     = 1'b0;
        pat[0]    = 7'h00; pat[1] = 7'h00; pat[2] = 7'h00;
        bout_seen = 8'h00; ecode_seen = 2'b00; edigit_seen = 2'd0;
        test_reset();
        test_basic();
        test_pattern_error();
        test_overflow();
        test_extremes();
        test_mid_reset();
        test_back_to_back();
        test_confirm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
